// File: rtl/pio_read_arbiter.sv
// Purpose: round-robin share of one read-only, fixed 1-cycle-latency Avalon-MM PIO slave among NUM_REQ read masters.
// Latency: request seen in IDLE at t -> accepted (waitrequest low) at t+1, slave sampled at t+2, readdatavalid at t+3.
// Backpressure: only the granted master sees waitrequest low, one cycle, in ISSUE; one access in flight, one read per 3 cycles.
module pio_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic [ADDR_W-1:0]           slv_address,
  input  logic [DATA_W-1:0]           slv_readdata,
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [ADDR_W-1:0]    slv_address_q;
  logic [DATA_W-1:0]    readdata_q;
  logic [NUM_REQ-1:0]   readdatavalid_q;

  logic [IDX_W-1:0]     pick_idx_d;
  logic                 pick_vld_d;
  logic [IDX_W-1:0]     rr_ptr_d;
  int                   cand;

  // Round-robin pick: first requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_idx_d = '0;
    pick_vld_d = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_vld_d && req_read[cand]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = IDX_W'(cand);
      end
    end
  end

  // Pointer moves to the slot after the accepted requester, so it loses to any other pending master next time.
  always_comb begin
    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
  end

  // Everyone asking is stalled except the granted master during its single ISSUE cycle.
  always_comb begin
    req_waitrequest = req_read;
    if (state_q == ISSUE) begin
      req_waitrequest[grant_q] = 1'b0;
    end
  end

  // Issue/capture sequencer; all slave-facing and return outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      rr_ptr_q        <= '0;
      slv_address_q   <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= '0;
    end else begin
      readdatavalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            grant_q       <= pick_idx_d;
            slv_address_q <= req_address[pick_idx_d*ADDR_W +: ADDR_W];
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          // A master that dropped read before acceptance is abandoned without moving the pointer.
          if (req_read[grant_q]) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= CAPTURE;
          end else begin
            state_q  <= IDLE;
          end
        end
        CAPTURE: begin
          readdata_q               <= slv_readdata;
          readdatavalid_q[grant_q] <= 1'b1;
          state_q                  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign slv_address       = slv_address_q;
  assign req_readdata      = readdata_q;
  assign req_readdatavalid = readdatavalid_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Purpose: self-checking bench for pio_read_arbiter with a 2-master and a 4-master instance, each on a modelled PIO slave.
// Latency: the PIO model returns the word at slv_address one clock after it is presented.
// Backpressure: masters hold read until waitrequest is low, except where a vector drops it deliberately.
module tb_pio_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] pio_regs [4];

  logic        rst2_n;
  logic [1:0]  rd2;
  logic [3:0]  addr2;
  logic [1:0]  wr2;
  logic [1:0]  vld2;
  logic [31:0] data2;
  logic [1:0]  saddr2;
  logic [31:0] sdata2;
  logic        busy2;

  logic        rst4_n;
  logic [3:0]  rd4;
  logic [7:0]  addr4;
  logic [3:0]  wr4;
  logic [3:0]  vld4;
  logic [31:0] data4;
  logic [1:0]  saddr4;
  logic [31:0] sdata4;
  logic        busy4;

  pio_read_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(2)) dut2 (
    .clk(clk), .reset_n(rst2_n), .req_read(rd2), .req_address(addr2),
    .req_waitrequest(wr2), .req_readdata(data2), .req_readdatavalid(vld2),
    .slv_address(saddr2), .slv_readdata(sdata2), .busy(busy2)
  );

  pio_read_arbiter #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(2)) dut4 (
    .clk(clk), .reset_n(rst4_n), .req_read(rd4), .req_address(addr4),
    .req_waitrequest(wr4), .req_readdata(data4), .req_readdatavalid(vld4),
    .slv_address(saddr4), .slv_readdata(sdata4), .busy(busy4)
  );

  // PIO slaves: registered readdata, one cycle after the address is presented.
  always @(posedge clk) begin
    sdata2 <= pio_regs[saddr2];
    sdata4 <= pio_regs[saddr4];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %08h required %08h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rst_n;
    logic [1:0]  rd;
    logic [3:0]  addr;
    logic [1:0]  wr;
    logic [1:0]  vld;
    logic [31:0] data;
    logic [1:0]  saddr;
    logic        busy;
  } vec_t;

  vec_t vecs [24];
  int   gseq4 [9];

  initial begin
    logic [1:0] ew2;
    logic [1:0] ev2;
    logic [3:0] ew4;
    logic [3:0] ev4;
    int wlow0;
    int wlow1;

    pio_regs[0] = 32'hDEADBEEF;
    pio_regs[1] = 32'h12345678;
    pio_regs[2] = 32'h00000000;
    pio_regs[3] = 32'hCAFEF00D;

    gseq4 = '{0, 1, 2, 3, 0, 2, 2, 2, 2};

    //            rst   rd     addr     wr     vld    data          saddr  busy
    vecs[0]  = '{1'b0, 2'b11, 4'b0000, 2'b11, 2'b00, 32'h00000000, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 2'b01, 4'b0000, 2'b01, 2'b00, 32'h00000000, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 2'b01, 4'b0000, 2'b00, 2'b00, 32'h00000000, 2'd0, 1'b1};
    vecs[3]  = '{1'b1, 2'b00, 4'b0000, 2'b00, 2'b00, 32'h00000000, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 2'b00, 4'b0000, 2'b00, 2'b01, 32'hDEADBEEF, 2'd0, 1'b0};
    vecs[5]  = '{1'b1, 2'b00, 4'b0000, 2'b00, 2'b00, 32'hDEADBEEF, 2'd0, 1'b0};
    vecs[6]  = '{1'b1, 2'b10, 4'b1000, 2'b10, 2'b00, 32'hDEADBEEF, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 2'b10, 4'b1000, 2'b00, 2'b00, 32'hDEADBEEF, 2'd2, 1'b1};
    vecs[8]  = '{1'b1, 2'b00, 4'b1000, 2'b00, 2'b00, 32'hDEADBEEF, 2'd2, 1'b1};
    vecs[9]  = '{1'b1, 2'b00, 4'b1000, 2'b00, 2'b10, 32'h00000000, 2'd2, 1'b0};
    vecs[10] = '{1'b1, 2'b00, 4'b1000, 2'b00, 2'b00, 32'h00000000, 2'd2, 1'b0};
    vecs[11] = '{1'b1, 2'b01, 4'b0011, 2'b01, 2'b00, 32'h00000000, 2'd2, 1'b0};
    vecs[12] = '{1'b1, 2'b00, 4'b0011, 2'b00, 2'b00, 32'h00000000, 2'd3, 1'b1};
    vecs[13] = '{1'b1, 2'b11, 4'b0111, 2'b11, 2'b00, 32'h00000000, 2'd3, 1'b0};
    vecs[14] = '{1'b1, 2'b11, 4'b0111, 2'b10, 2'b00, 32'h00000000, 2'd3, 1'b1};
    vecs[15] = '{1'b1, 2'b11, 4'b0111, 2'b11, 2'b00, 32'h00000000, 2'd3, 1'b1};
    vecs[16] = '{1'b1, 2'b11, 4'b0111, 2'b11, 2'b01, 32'hCAFEF00D, 2'd3, 1'b0};
    vecs[17] = '{1'b1, 2'b11, 4'b0111, 2'b01, 2'b00, 32'hCAFEF00D, 2'd1, 1'b1};
    vecs[18] = '{1'b1, 2'b01, 4'b0111, 2'b01, 2'b00, 32'hCAFEF00D, 2'd1, 1'b1};
    vecs[19] = '{1'b1, 2'b01, 4'b0111, 2'b01, 2'b10, 32'h12345678, 2'd1, 1'b0};
    vecs[20] = '{1'b1, 2'b01, 4'b0111, 2'b00, 2'b00, 32'h12345678, 2'd3, 1'b1};
    vecs[21] = '{1'b0, 2'b00, 4'b0111, 2'b00, 2'b00, 32'h12345678, 2'd3, 1'b1};
    vecs[22] = '{1'b1, 2'b00, 4'b0111, 2'b00, 2'b00, 32'h00000000, 2'd0, 1'b0};
    vecs[23] = '{1'b1, 2'b00, 4'b0111, 2'b00, 2'b00, 32'h00000000, 2'd0, 1'b0};

    rst2_n = 1'b0; rd2 = 2'b11; addr2 = '0;
    rst4_n = 1'b0; rd4 = '0;    addr4 = '0;
    repeat (2) @(posedge clk);

    // Directed vectors on the 2-master instance: reset, single reads, ISSUE abort, re-request fairness, reset in CAPTURE.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst2_n = vecs[i].rst_n;
      rd2    = vecs[i].rd;
      addr2  = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d waitrequest", i), 32'(wr2),    32'(vecs[i].wr));
      chk($sformatf("vec%0d valid", i),       32'(vld2),   32'(vecs[i].vld));
      chk($sformatf("vec%0d readdata", i),    data2,       vecs[i].data);
      chk($sformatf("vec%0d slv_address", i), 32'(saddr2), 32'(vecs[i].saddr));
      chk($sformatf("vec%0d busy", i),        32'(busy2),  32'(vecs[i].busy));
    end

    // Contention on 2 masters, both reading continuously from reset: grants alternate 0,1,0,1.
    @(negedge clk);
    rst2_n = 1'b0; rd2 = 2'b11; addr2 = 4'b1100;
    repeat (2) @(posedge clk);
    wlow0 = 0;
    wlow1 = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      rst2_n = 1'b1;
      #1;
      ew2 = 2'b11;
      if (c % 3 == 1) ew2[(c / 3) % 2] = 1'b0;
      ev2 = 2'b00;
      if (c > 0 && c % 3 == 0) ev2[(c / 3 - 1) % 2] = 1'b1;
      chk($sformatf("cont c%0d waitrequest", c), 32'(wr2),  32'(ew2));
      chk($sformatf("cont c%0d valid", c),       32'(vld2), 32'(ev2));
      if (ev2 != 2'b00) chk($sformatf("cont c%0d readdata", c), data2, ev2[0] ? pio_regs[0] : pio_regs[3]);
      if (c < 12) begin
        if (!wr2[0]) wlow0++;
        if (!wr2[1]) wlow1++;
      end
    end
    chk("cont wait0 low count", 32'(wlow0), 32'd2);
    chk("cont wait1 low count", 32'(wlow1), 32'd2);
    rd2 = 2'b00;

    // 4 masters: all requesting gives 0,1,2,3,0 with wrap; then only master 2 gets four back-to-back grants.
    @(negedge clk);
    rst4_n = 1'b0; rd4 = 4'b1111; addr4 = 8'b11_10_01_00;
    repeat (2) @(posedge clk);
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      rst4_n = 1'b1;
      rd4 = (c < 15) ? 4'b1111 : 4'b0100;
      #1;
      ew4 = rd4;
      if (c % 3 == 1) ew4[gseq4[c / 3]] = 1'b0;
      ev4 = 4'b0000;
      if (c > 0 && c % 3 == 0) ev4[gseq4[c / 3 - 1]] = 1'b1;
      chk($sformatf("rr4 c%0d waitrequest", c), 32'(wr4),   32'(ew4));
      chk($sformatf("rr4 c%0d valid", c),       32'(vld4),  32'(ev4));
      chk($sformatf("rr4 c%0d busy", c),        32'(busy4), (c % 3 != 0) ? 32'd1 : 32'd0);
      if (ev4 != 4'b0000) chk($sformatf("rr4 c%0d readdata", c), data4, pio_regs[gseq4[c / 3 - 1]]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
